// File: rtl/data_mem_responder.sv
// Wait-state load/store responder: one request in flight, RISC-V byte/half/word
// access with sign/zero extension, response strobe after LATENCY wait cycles.

module data_mem_byte_lane #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    // Contents start at zero and are deliberately not touched by reset.
    logic [7:0] mem [DEPTH] = '{default: 8'h00};

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int         NUM_LANES = 4;
    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT4      = 4'(LATENCY);
    localparam bit         ZERO_LAT  = (LATENCY == 0);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } memReq_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } memResp_t;

    logic [1:0]  state;
    logic [3:0]  waitCnt;
    memReq_t     reqQ;
    memReq_t     accReq;
    memResp_t    accResp;
    logic        enterResp;
    logic        commit;

    logic [AW-1:0]                  wordIdx;
    logic [1:0]                     lane;
    logic                           inRange;
    logic                           illegal;
    logic                           misaligned;
    logic                           fault;
    logic [NUM_LANES-1:0]           byteEn;
    logic [NUM_LANES-1:0]           laneWe;
    logic [NUM_LANES-1:0][7:0]      laneWdata;
    logic [NUM_LANES-1:0][7:0]      rdWord;
    logic [7:0]                     rdByte;
    logic [15:0]                    rdHalf;
    logic [31:0]                    loadData;

    // With zero latency the access resolves on the accepting edge itself, so
    // the decode must see the live request rather than the latched copy.
    assign accReq = (state == IDLE) ?
        '{we: we, funct3: funct3, addr: addr, wdata: wdata} : reqQ;

    assign enterResp = ((state == IDLE) && req && ZERO_LAT) ||
                       ((state == WAIT) && (waitCnt == 4'd1));
    assign commit    = enterResp && !rst && accReq.we && !fault;

    assign wordIdx = accReq.addr[AW+1:2];
    assign lane    = accReq.addr[1:0];
    assign inRange = {2'b00, accReq.addr[31:2]} < 32'(DEPTH);

    always_comb begin
        illegal = 1'b0;
        if (accReq.we) illegal = (accReq.funct3 > 3'd2);
        else begin
            case (accReq.funct3)
                3'd3, 3'd6, 3'd7: illegal = 1'b1;
                default:          illegal = 1'b0;
            endcase
        end

        misaligned = 1'b0;
        case (accReq.funct3[1:0])
            2'd1:    misaligned = lane[0];
            2'd2:    misaligned = (lane != 2'd0);
            default: misaligned = 1'b0;
        endcase

        fault = illegal || misaligned || !inRange;

        byteEn    = '0;
        laneWdata = accReq.wdata;
        case (accReq.funct3[1:0])
            2'd0: begin
                byteEn    = 4'b0001 << lane;
                laneWdata = {4{accReq.wdata[7:0]}};
            end
            2'd1: begin
                byteEn    = lane[1] ? 4'b1100 : 4'b0011;
                laneWdata = {2{accReq.wdata[15:0]}};
            end
            2'd2:    byteEn = 4'b1111;
            default: byteEn = '0;
        endcase
    end

    assign laneWe = commit ? byteEn : '0;

    for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
        data_mem_byte_lane #(.DEPTH(DEPTH), .AW(AW)) uLane (
            .clk   (clk),
            .we    (laneWe[i]),
            .idx   (wordIdx),
            .wdata (laneWdata[i]),
            .rdata (rdWord[i])
        );
    end

    assign rdByte = rdWord[lane];
    assign rdHalf = lane[1] ? rdWord[3:2] : rdWord[1:0];

    always_comb begin
        loadData = '0;
        case (accReq.funct3)
            3'd0:    loadData = {{24{rdByte[7]}}, rdByte};
            3'd1:    loadData = {{16{rdHalf[15]}}, rdHalf};
            3'd2:    loadData = rdWord;
            3'd4:    loadData = {24'h0, rdByte};
            3'd5:    loadData = {16'h0, rdHalf};
            default: loadData = '0;
        endcase
        accResp.err  = fault;
        accResp.data = (fault || accReq.we) ? 32'h0 : loadData;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ready   <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            waitCnt <= '0;
            reqQ    <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    reqQ    <= accReq;
                    waitCnt <= LAT4;
                    busy    <= 1'b1;
                    state   <= ZERO_LAT ? RESP : WAIT;
                end
                WAIT:    waitCnt <= waitCnt - 4'd1;
                RESP: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
            if (enterResp) begin
                state <= RESP;
                ready <= 1'b1;
                rdata <= accResp.data;
                err   <= accResp.err;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances at LATENCY 2, 3 and 0
// share the request bus; each has its own req and response signals.

module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  reqV = '0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  busyV, readyV, errV;
    logic [31:0] rdataV [3];

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) uDut2 (
        .clk(clk), .rst(rst), .req(reqV[0]), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .busy(busyV[0]), .ready(readyV[0]), .rdata(rdataV[0]), .err(errV[0]));
    data_mem_responder #(.DEPTH(256), .LATENCY(3)) uDut3 (
        .clk(clk), .rst(rst), .req(reqV[1]), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .busy(busyV[1]), .ready(readyV[1]), .rdata(rdataV[1]), .err(errV[1]));
    data_mem_responder #(.DEPTH(256), .LATENCY(0)) uDut0 (
        .clk(clk), .rst(rst), .req(reqV[2]), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .busy(busyV[2]), .ready(readyV[2]), .rdata(rdataV[2]), .err(errV[2]));

    // Called at a negedge with the selected instance idle; returns at the
    // negedge after the ready cycle, when that instance is idle again.
    task automatic doAccess(input int d, input logic w, input logic [2:0] f,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic e, output int lat,
                            output logic bsyResp, output logic rdyAfter);
        we = w; funct3 = f; addr = a; wdata = wd; reqV[d] = 1'b1;
        @(posedge clk); #1;
        reqV[d] = 1'b0; we = ~w; funct3 = 3'd7; addr = 32'hFFFF_FFFC; wdata = 32'h5A5A_5A5A;
        lat = -1; rd = '0; e = 1'b0; bsyResp = 1'b0; rdyAfter = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (readyV[d]) begin
                lat = c; rd = rdataV[d]; e = errV[d]; bsyResp = busyV[d];
                break;
            end
        end
        if (lat != -1) begin
            @(negedge clk);
            rdyAfter = readyV[d];
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd; logic e, br, ra; int lat;
        reqV[0] = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            nVec++;
            if (busyV[0] !== 1'b0 || readyV[0] !== 1'b0 || rdataV[0] !== 32'h0 || errV[0] !== 1'b0) begin
                nErr++;
                $display("FAIL reset_state busy=%b ready=%b rdata=%h err=%b want 0/0/00000000/0",
                         busyV[0], readyV[0], rdataV[0], errV[0]);
            end
        end
        rst = 1'b0; reqV[0] = 1'b0;
        doAccess(0, 1'b0, 3'd2, 32'h0, 32'h0, rd, e, lat, br, ra);
        nVec++;
        if (lat !== 3 || rd !== 32'h0 || e !== 1'b0) begin
            nErr++; $display("FAIL first_lw lat=%0d rdata=%h err=%b want 3/00000000/0", lat, rd, e);
        end
        nVec++;
        if (br !== 1'b1 || ra !== 1'b0) begin
            nErr++; $display("FAIL ready_one_cycle busy@resp=%b ready_after=%b want 1/0", br, ra);
        end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic e, br, ra; int lat;
        doAccess(0, 1'b1, 3'd2, 32'h10, 32'h1234_5678, rd, e, lat, br, ra);
        nVec++;
        if (lat !== 3 || rd !== 32'h0 || e !== 1'b0) begin
            nErr++; $display("FAIL sw_10 lat=%0d rdata=%h err=%b want 3/00000000/0", lat, rd, e);
        end
        doAccess(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, e, lat, br, ra);
        nVec++;
        if (rd !== 32'h1234_5678 || e !== 1'b0) begin
            nErr++; $display("FAIL lw_10 rdata=%h err=%b want 12345678/0", rd, e);
        end
        doAccess(0, 1'b0, 3'd0, 32'h13, 32'h0, rd, e, lat, br, ra);
        nVec++;
        if (rd !== 32'h0000_0012 || e !== 1'b0) begin
            nErr++; $display("FAIL lb_13 rdata=%h err=%b want 00000012/0", rd, e);
        end
        doAccess(0, 1'b0, 3'd4, 32'h10, 32'h0, rd, e, lat, br, ra);
        nVec++;
        if (rd !== 32'h0000_0078 || e !== 1'b0) begin
            nErr++; $display("FAIL lbu_10 rdata=%h err=%b want 00000078/0", rd, e);
        end
    endtask

    task automatic test_sign_lanes;
        logic [31:0] rd; logic e, br, ra; int lat;
        logic [2:0]  fv [5] = '{3'd1, 3'd5, 3'd0, 3'd0, 3'd2};
        logic [31:0] av [5] = '{32'h22, 32'h22, 32'h21, 32'h23, 32'h20};
        logic [31:0] ev [5] = '{32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_007F, 32'hFFFF_FF80, 32'h80FF_7F01};
        doAccess(0, 1'b1, 3'd2, 32'h20, 32'h80FF_7F01, rd, e, lat, br, ra);
        for (int i = 0; i < 5; i++) begin
            doAccess(0, 1'b0, fv[i], av[i], 32'h0, rd, e, lat, br, ra);
            nVec++;
            if (rd !== ev[i] || e !== 1'b0) begin
                nErr++; $display("FAIL ld_f%0d_%h rdata=%h err=%b want %h/0", fv[i], av[i], rd, e, ev[i]);
            end
        end
        doAccess(0, 1'b1, 3'd0, 32'h21, 32'h1234_56AA, rd, e, lat, br, ra);
        doAccess(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, e, lat, br, ra);
        nVec++;
        if (rd !== 32'h80FF_AA01 || e !== 1'b0) begin
            nErr++; $display("FAIL sb_21_lw rdata=%h err=%b want 80FFAA01/0", rd, e);
        end
        doAccess(0, 1'b1, 3'd1, 32'h22, 32'h9999_BEEF, rd, e, lat, br, ra);
        doAccess(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, e, lat, br, ra);
        nVec++;
        if (rd !== 32'hBEEF_AA01 || e !== 1'b0) begin
            nErr++; $display("FAIL sh_22_lw rdata=%h err=%b want BEEFAA01/0", rd, e);
        end
    endtask

    task automatic test_faults;
        logic [31:0] rd; logic e, br, ra; int lat;
        logic        wv [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  fv [5] = '{3'd2, 3'd1, 3'd2, 3'd3, 3'd3};
        logic [31:0] av [5] = '{32'h22, 32'h21, 32'h400, 32'h20, 32'h20};
        for (int i = 0; i < 5; i++) begin
            doAccess(0, wv[i], fv[i], av[i], 32'h1111_1111, rd, e, lat, br, ra);
            nVec++;
            if (lat !== 3 || rd !== 32'h0 || e !== 1'b1) begin
                nErr++;
                $display("FAIL fault_%0d lat=%0d rdata=%h err=%b want 3/00000000/1", i, lat, rd, e);
            end
        end
        doAccess(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, e, lat, br, ra);
        nVec++;
        if (rd !== 32'hBEEF_AA01 || e !== 1'b0) begin
            nErr++; $display("FAIL fault_nowrite rdata=%h err=%b want BEEFAA01/0", rd, e);
        end
        doAccess(0, 1'b0, 3'd2, 32'h3FC, 32'h0, rd, e, lat, br, ra);
        nVec++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            nErr++; $display("FAIL last_word rdata=%h err=%b want 00000000/0", rd, e);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic e, br, ra; int lat;
        doAccess(0, 1'b1, 3'd2, 32'h40, 32'hCAFE_F00D, rd, e, lat, br, ra);
        doAccess(0, 1'b0, 3'd2, 32'h40, 32'h0, rd, e, lat, br, ra);
        nVec++;
        if (lat !== 3 || rd !== 32'hCAFE_F00D || e !== 1'b0) begin
            nErr++; $display("FAIL b2b_lw lat=%0d rdata=%h err=%b want 3/CAFEF00D/0", lat, rd, e);
        end
    endtask

    task automatic test_busy_ignore;
        logic expR, expB;
        int   nReady = 0;
        we = 1'b0; funct3 = 3'd2; addr = 32'h0; reqV[1] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            addr = 32'(c * 4);
            @(negedge clk);
            expR = ((c % 5) == 4);
            expB = ((c % 5) != 0);
            if (readyV[1] === 1'b1) nReady++;
            nVec++;
            if (readyV[1] !== expR || busyV[1] !== expB) begin
                nErr++;
                $display("FAIL busy_c%0d ready=%b busy=%b want %b/%b", c, readyV[1], busyV[1], expR, expB);
            end
        end
        reqV[1] = 1'b0;
        nVec++;
        if (nReady !== 4) begin
            nErr++; $display("FAIL busy_count responses=%0d want 4", nReady);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic e, br, ra; int lat;
        logic sawReady = 1'b0;
        we = 1'b1; funct3 = 3'd2; addr = 32'h30; wdata = 32'hDEAD_BEEF; reqV[0] = 1'b1;
        @(posedge clk); #1;
        reqV[0] = 1'b0;
        @(negedge clk);
        nVec++;
        if (busyV[0] !== 1'b1) begin
            nErr++; $display("FAIL mid_busy busy=%b want 1", busyV[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nVec++;
        if (busyV[0] !== 1'b0 || readyV[0] !== 1'b0) begin
            nErr++; $display("FAIL mid_abort busy=%b ready=%b want 0/0", busyV[0], readyV[0]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (readyV[0] === 1'b1) sawReady = 1'b1;
        end
        nVec++;
        if (sawReady !== 1'b0) begin
            nErr++; $display("FAIL mid_noready ready_seen=%b want 0", sawReady);
        end
        doAccess(0, 1'b0, 3'd2, 32'h30, 32'h0, rd, e, lat, br, ra);
        nVec++;
        if (lat !== 3 || rd !== 32'h0 || e !== 1'b0) begin
            nErr++; $display("FAIL mid_lw30 lat=%0d rdata=%h err=%b want 3/00000000/0", lat, rd, e);
        end
    endtask

    task automatic test_lat0;
        logic [31:0] rd; logic e, br, ra; int lat;
        doAccess(2, 1'b1, 3'd2, 32'h30, 32'hDEAD_BEEF, rd, e, lat, br, ra);
        nVec++;
        if (lat !== 1 || rd !== 32'h0 || e !== 1'b0 || ra !== 1'b0) begin
            nErr++; $display("FAIL l0_sw lat=%0d rdata=%h err=%b rdyAfter=%b want 1/00000000/0/0", lat, rd, e, ra);
        end
        doAccess(2, 1'b0, 3'd2, 32'h30, 32'h0, rd, e, lat, br, ra);
        nVec++;
        if (lat !== 1 || rd !== 32'hDEAD_BEEF || e !== 1'b0) begin
            nErr++; $display("FAIL l0_lw lat=%0d rdata=%h err=%b want 1/DEADBEEF/0", lat, rd, e);
        end
        rst = 1'b1; reqV[2] = 1'b1;
        we = 1'b1; funct3 = 3'd2; addr = 32'h30; wdata = 32'h1111_1111;
        @(negedge clk);
        nVec++;
        if (readyV[2] !== 1'b0 || busyV[2] !== 1'b0) begin
            nErr++; $display("FAIL l0_rst_dom ready=%b busy=%b want 0/0", readyV[2], busyV[2]);
        end
        rst = 1'b0; reqV[2] = 1'b0;
        doAccess(2, 1'b0, 3'd2, 32'h30, 32'h0, rd, e, lat, br, ra);
        nVec++;
        if (lat !== 1 || rd !== 32'hDEAD_BEEF || e !== 1'b0) begin
            nErr++; $display("FAIL l0_nowrite lat=%0d rdata=%h err=%b want 1/DEADBEEF/0", lat, rd, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_sign_lanes();
        test_faults();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_lat0();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
